// File: rtl/lcd_timing_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_timing_pattern_gen
// Description : RGB-LCD timing generator (hsync/vsync/de) with run-time
//               selectable test patterns, frame counter and enable/standby
//               sequencing. All panel pins are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_pattern_gen #(
    parameter int H_ACTIVE  = 480,
    parameter int H_FP      = 8,
    parameter int H_SYNC    = 4,
    parameter int H_BP      = 43,
    parameter int V_ACTIVE  = 272,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 12,
    parameter int COLOR_W   = 8,
    parameter int GRID_LOG2 = 4,
    parameter bit SYNC_POL  = 1'b0,
    parameter bit REV_DEF   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   rev,
    output logic                   stby,
    output logic [15:0]            frame_cnt,
    output logic                   frame_sof
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are at least as wide as the pattern slices taken from them.
    localparam int c_H_W = f_max(f_max($clog2(c_H_TOT), COLOR_W), GRID_LOG2);
    localparam int c_V_W = f_max($clog2(c_V_TOT), GRID_LOG2);

    localparam logic [c_H_W-1:0] c_H_LAST = c_H_W'(c_H_TOT - 1);
    localparam logic [c_H_W-1:0] c_H_ACT  = c_H_W'(H_ACTIVE);
    localparam logic [c_H_W-1:0] c_HS_BEG = c_H_W'(H_ACTIVE + H_FP);
    localparam logic [c_H_W-1:0] c_HS_END = c_H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_V_W-1:0] c_V_LAST = c_V_W'(c_V_TOT - 1);
    localparam logic [c_V_W-1:0] c_V_ACT  = c_V_W'(V_ACTIVE);
    localparam logic [c_V_W-1:0] c_VS_BEG = c_V_W'(V_ACTIVE + V_FP);
    localparam logic [c_V_W-1:0] c_VS_END = c_V_W'(V_ACTIVE + V_FP + V_SYNC);

    // Colour-bar width in pixels; a sub-counter replaces a divide by it.
    localparam int                c_BAR_PX   = H_ACTIVE / 8;
    localparam int                c_BAR_CW   = f_max(1, $clog2(c_BAR_PX));
    localparam logic [c_BAR_CW-1:0] c_BAR_LAST = c_BAR_CW'(c_BAR_PX - 1);

    localparam logic c_SYNC_IDLE = ~SYNC_POL;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_H_W-1:0]      r_h;
    logic [c_V_W-1:0]      r_v;
    logic [c_BAR_CW-1:0]   r_bar_cnt;
    logic [2:0]            r_bar_idx;
    logic [1:0]            r_mode;
    logic [3*COLOR_W-1:0]  r_solid;

    logic                  w_run;
    logic                  w_line_end;
    logic                  w_frame_end;
    logic                  w_sof_pt;
    logic                  w_h_act;
    logic                  w_de;
    logic                  w_hs_act;
    logic                  w_vs_act;
    logic                  w_white;
    logic [1:0]            w_mode_cur;
    logic [3*COLOR_W-1:0]  w_solid_cur;
    logic [3*COLOR_W-1:0]  w_rgb;

    assign w_run       = (r_state == S_RUN);
    assign w_line_end  = (r_h == c_H_LAST);
    assign w_frame_end = w_line_end && (r_v == c_V_LAST);
    assign w_sof_pt    = (r_h == '0) && (r_v == '0);
    assign w_h_act     = (r_h < c_H_ACT);

    // At the frame origin the live inputs apply, so the first pixel already
    // uses the newly latched mode; elsewhere the latched copy is held.
    assign w_mode_cur  = w_sof_pt ? mode      : r_mode;
    assign w_solid_cur = w_sof_pt ? solid_rgb : r_solid;

    assign rev = REV_DEF;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state: leave RUN only on the last clock of a frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_next = S_RUN;
            S_RUN:   if (!en && w_frame_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Horizontal / vertical position counters, held at 0 while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (!w_run) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_line_end) begin
            r_h <= '0;
            r_v <= w_frame_end ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Colour-bar sub-counter: pixel within bar and bar index along the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!w_run || w_line_end) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (w_h_act) begin
            if (r_bar_cnt == c_BAR_LAST) begin
                r_bar_cnt <= '0;
                r_bar_idx <= r_bar_idx + 1'b1;
            end else begin
                r_bar_cnt <= r_bar_cnt + 1'b1;
            end
        end
    end

    // Pattern selection is latched once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= '0;
            r_solid <= '0;
        end else begin
            r_mode  <= w_mode_cur;
            r_solid <= w_solid_cur;
        end
    end

    // Region decode and pixel pattern for the current counter position.
    always_comb begin
        w_de     = w_run && w_h_act && (r_v < c_V_ACT);
        w_hs_act = w_run && (r_h >= c_HS_BEG) && (r_h < c_HS_END);
        w_vs_act = w_run && (r_v >= c_VS_BEG) && (r_v < c_VS_END);
        w_white  = (r_h[GRID_LOG2-1:0] == '0) || (r_v[GRID_LOG2-1:0] == '0);
        w_rgb    = '0;
        if (w_de) begin
            case (w_mode_cur)
                2'd0: w_rgb = w_solid_cur;
                2'd1: w_rgb = {{COLOR_W{r_bar_idx[2]}},
                               {COLOR_W{r_bar_idx[1]}},
                               {COLOR_W{r_bar_idx[0]}}};
                2'd2: w_rgb = w_white ? '1 : '0;
                default: w_rgb = {3{r_h[COLOR_W-1:0]}};
            endcase
        end
    end

    // Registered panel pins, one clock behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync     <= c_SYNC_IDLE;
            vsync     <= c_SYNC_IDLE;
            de        <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            stby      <= 1'b0;
            frame_sof <= 1'b0;
        end else begin
            hsync     <= w_hs_act ^ c_SYNC_IDLE;
            vsync     <= w_vs_act ^ c_SYNC_IDLE;
            de        <= w_de;
            r         <= w_rgb[3*COLOR_W-1:2*COLOR_W];
            g         <= w_rgb[2*COLOR_W-1:COLOR_W];
            b         <= w_rgb[COLOR_W-1:0];
            stby      <= (w_state_next == S_RUN);
            frame_sof <= w_run && w_sof_pt;
        end
    end

    // Completed-frame counter; holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      frame_cnt <= '0;
        else if (w_run && w_frame_end) frame_cnt <= frame_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_timing_pattern_gen
// Description : Self-checking bench for lcd_timing_pattern_gen on a small
//               8x4 panel; flat-position reference model plus vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_pattern_gen;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int COLOR_W = 4, GRID_LOG2 = 2;
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;
    localparam logic [33:0] c_RST_PINS = {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16'h0000};

    logic clk = 1'b0;
    logic rst, en;
    logic [1:0] mode;
    logic [11:0] solid_rgb;
    logic hsync, vsync, de, rev, stby, frame_sof;
    logic [3:0] r, g, b;
    logic [15:0] frame_cnt;

    lcd_timing_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLOR_W(COLOR_W), .GRID_LOG2(GRID_LOG2), .SYNC_POL(1'b0), .REV_DEF(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
        .rev(rev), .stby(stby), .frame_cnt(frame_cnt), .frame_sof(frame_sof)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int sof_q[$];

    // Reference model: one flat position 0..F_TOT-1 per frame.
    bit         m_run = 1'b0;
    int         m_pos = 0;
    int         m_frames = 0;
    logic [1:0] m_mode = 2'd0;
    logic [11:0] m_solid = 12'h000;
    int         m_x, m_y;
    bit         m_de;
    logic [11:0] cap [0:V_TOT-1][0:H_TOT-1];

    typedef struct {
        string       name;
        logic [1:0]  md;
        int          x;
        int          y;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t vt[$];

    function automatic logic [33:0] pins();
        return {hsync, vsync, de, r, g, b, stby, frame_sof, rev, frame_cnt};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [11:0] pattern(input logic [1:0] md, input logic [11:0] sol,
                                            input int x, input int y);
        int idx;
        logic [3:0] xv;
        idx = x / (H_ACTIVE / 8);
        xv  = 4'(x % 16);
        case (md)
            2'd0: return sol;
            2'd1: return {((idx / 4) % 2 == 1) ? 4'hF : 4'h0,
                          ((idx / 2) % 2 == 1) ? 4'hF : 4'h0,
                          (idx % 2 == 1)       ? 4'hF : 4'h0};
            2'd2: return ((x % 4 == 0) || (y % 4 == 0)) ? 12'hFFF : 12'h000;
            default: return {xv, xv, xv};
        endcase
    endfunction

    // Expected pins after the coming edge, from current model state and inputs.
    task automatic model_edge(output logic [33:0] e);
        logic hs, vs, sof;
        logic [11:0] rgb;
        hs = 1'b1; vs = 1'b1; sof = 1'b0; rgb = 12'h000; m_de = 1'b0;
        if (!m_run) begin
            m_run = en;
            m_pos = 0;
        end else begin
            m_x = m_pos % H_TOT;
            m_y = m_pos / H_TOT;
            if (m_pos == 0) begin
                m_mode  = mode;
                m_solid = solid_rgb;
                sof     = 1'b1;
            end
            m_de = (m_x < H_ACTIVE) && (m_y < V_ACTIVE);
            hs = !((m_x >= H_ACTIVE + H_FP) && (m_x < H_ACTIVE + H_FP + H_SYNC));
            vs = !((m_y >= V_ACTIVE + V_FP) && (m_y < V_ACTIVE + V_FP + V_SYNC));
            if (m_de) rgb = pattern(m_mode, m_solid, m_x, m_y);
            if (m_pos == F_TOT - 1) begin
                m_frames++;
                m_pos = 0;
                if (!en) m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end
        e = {hs, vs, m_de, rgb, m_run, sof, 1'b0, 16'(m_frames)};
    endtask

    task automatic tick(input string tag);
        logic [33:0] e;
        model_edge(e);
        @(posedge clk);
        @(negedge clk);
        chk(tag, 64'(pins()), 64'(e));
        if (m_de) cap[m_y][m_x] = {r, g, b};
        if (frame_sof) sof_q.push_back(cyc);
        cyc++;
    endtask

    // Advance to a frame boundary (bounded), then run exactly one frame.
    task automatic run_one_frame(input string tag);
        int guard;
        guard = 0;
        while (!(m_run && m_pos == 0) && guard < 3 * F_TOT) begin
            tick(tag);
            guard++;
        end
        if (guard >= 3 * F_TOT) chk({tag, "_align_timeout"}, 64'(guard), 64'(0));
        repeat (F_TOT) tick(tag);
    endtask

    task automatic check_table(input logic [1:0] md);
        foreach (vt[i]) begin
            if (vt[i].md == md)
                chk(vt[i].name, 64'(cap[vt[i].y][vt[i].x]), 64'(vt[i].exp_rgb));
        end
    endtask

    initial begin
        // Vector table: expected pixels for bars, grid and gradient.
        vt.push_back('{"bar0", 2'd1, 0, 1, 12'h000});
        vt.push_back('{"bar1", 2'd1, 1, 1, 12'h00F});
        vt.push_back('{"bar2", 2'd1, 2, 1, 12'h0F0});
        vt.push_back('{"bar3", 2'd1, 3, 1, 12'h0FF});
        vt.push_back('{"bar4", 2'd1, 4, 1, 12'hF00});
        vt.push_back('{"bar5", 2'd1, 5, 1, 12'hF0F});
        vt.push_back('{"bar6", 2'd1, 6, 1, 12'hFF0});
        vt.push_back('{"bar7", 2'd1, 7, 1, 12'hFFF});
        vt.push_back('{"grid_y0_x3", 2'd2, 3, 0, 12'hFFF});
        vt.push_back('{"grid_y0_x6", 2'd2, 6, 0, 12'hFFF});
        vt.push_back('{"grid_y1_x0", 2'd2, 0, 1, 12'hFFF});
        vt.push_back('{"grid_y1_x1", 2'd2, 1, 1, 12'h000});
        vt.push_back('{"grid_y2_x4", 2'd2, 4, 2, 12'hFFF});
        vt.push_back('{"grid_y2_x5", 2'd2, 5, 2, 12'h000});
        vt.push_back('{"grid_y3_x7", 2'd2, 7, 3, 12'h000});
        vt.push_back('{"grad_x0", 2'd3, 0, 2, 12'h000});
        vt.push_back('{"grad_x3", 2'd3, 3, 2, 12'h333});
        vt.push_back('{"grad_x7", 2'd3, 7, 2, 12'h777});

        // Reset state.
        rst = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 12'hA53;
        repeat (2) @(negedge clk);
        chk("reset_pins", 64'(pins()), 64'(c_RST_PINS));
        rst = 1'b0;

        // Solid colour: timing and period.
        en = 1'b1;
        repeat (2 * F_TOT + 2) tick("solid");
        chk("solid_px0", 64'(cap[0][0]), 64'(12'hA53));
        chk("solid_px7_y3", 64'(cap[3][7]), 64'(12'hA53));
        if (sof_q.size() >= 2) chk("frame_period", 64'(sof_q[1] - sof_q[0]), 64'(F_TOT));
        else                   chk("frame_period_sof_missing", 64'(sof_q.size()), 64'(2));

        // Colour bars and grid.
        mode = 2'd1;
        run_one_frame("bars");
        check_table(2'd1);
        mode = 2'd2;
        run_one_frame("grid");
        check_table(2'd2);

        // Mode change mid-frame takes effect only on the next frame.
        mode = 2'd0; solid_rgb = 12'h5C7;
        run_one_frame("pre_switch");
        repeat (20) tick("switch");
        mode = 2'd3;
        repeat (F_TOT - 20) tick("switch");
        chk("switch_keeps_solid", 64'(cap[3][5]), 64'(12'h5C7));
        run_one_frame("gradient");
        check_table(2'd3);

        // en dropped mid-frame: frame completes, then standby.
        repeat (30) tick("en_drop");
        begin
            int f_snap;
            f_snap = m_frames;
            en = 1'b0;
            repeat (F_TOT - 30) tick("en_drop");
            chk("en_drop_frame_cnt", 64'(frame_cnt), 64'(16'(f_snap + 1)));
            chk("en_drop_stby", 64'(stby), 64'(0));
        end
        repeat (10) tick("idle");
        chk("idle_pins", 64'({hsync, vsync, de, stby}), 64'(4'b1100));

        // Reset asserted mid-line acts before the next clock edge.
        en = 1'b1; mode = 2'd0; solid_rgb = 12'hA53;
        repeat (F_TOT + 17) tick("pre_rst");
        #2 rst = 1'b1;
        #1 chk("async_rst_pins", 64'(pins()), 64'(c_RST_PINS));
        repeat (2) @(negedge clk);
        chk("rst_hold_pins", 64'(pins()), 64'(c_RST_PINS));
        rst = 1'b0;
        m_run = 1'b0; m_pos = 0; m_frames = 0;
        run_one_frame("post_rst");
        chk("post_rst_px0", 64'(cap[0][0]), 64'(12'hA53));
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(16'd1));

        // Randomised en / mode / colour activity against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) solid_rgb = 12'($urandom);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
